// File: rtl/timer_apb_slave_if.sv
// rtl/timer_apb_slave_if.sv - APB-style register bus between CPU master and timer slave
interface timer_apb_if #(
    parameter int ADDR_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [7:0]        pwdata;
    logic [7:0]        prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/timer_apb_slave.sv
// rtl/timer_apb_slave.sv - APB-style register responder for the 8-bit timer
module timer_apb_slave #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 8
) (
    input  logic         pclk,
    input  logic         presetn,
    timer_apb_if.slave   apb,
    output logic [7:0]   tdr,
    output logic         load,
    output logic         dw,
    output logic         en,
    output logic [1:0]   clk_sel,
    input  logic [7:0]   cnt,
    input  logic         ovf_set,
    input  logic         udf_set,
    output logic [1:0]   tsr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  wait_cnt, wait_nxt;
    logic        complete;
    logic        addr_valid;
    logic        access_err;
    logic        wr_commit;
    logic [1:0]  reg_sel;
    logic [7:0]  rd_mux;
    logic [1:0]  tsr_nxt;

    assign reg_sel    = apb.paddr[1:0];
    assign addr_valid = (apb.paddr < ADDR_W'(4));
    // Unmapped addresses and any write to the read-only counter are errors.
    assign access_err = !addr_valid || (apb.pwrite && reg_sel == 2'd3);
    assign wr_commit  = complete && apb.pwrite && !access_err;

    // FSM state and wait counter registers.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Next-state, wait-state countdown and completion strobe.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (apb.psel && !apb.penable) state_nxt = SETUP;
            end
            SETUP: begin
                if (apb.psel && apb.penable) begin
                    state_nxt = ACCESS;
                    wait_nxt  = 3'(WAIT_CYCLES);
                end else begin
                    state_nxt = IDLE;
                end
            end
            ACCESS: begin
                if (!apb.psel) begin
                    // Master walked away before completion: drop it silently.
                    state_nxt = IDLE;
                end else if (wait_cnt != 3'd0) begin
                    wait_nxt = wait_cnt - 3'd1;
                end else begin
                    complete  = 1'b1;
                    state_nxt = (apb.psel && !apb.penable) ? SETUP : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read mux; reserved bits and unmapped addresses return zero.
    always_comb begin
        rd_mux = 8'h00;
        if (addr_valid) begin
            case (reg_sel)
                2'd0:    rd_mux = tdr;
                2'd1:    rd_mux = {load, 1'b0, dw, en, 2'b00, clk_sel};
                2'd2:    rd_mux = {6'b0, tsr};
                default: rd_mux = cnt;
            endcase
        end
    end

    assign apb.pready  = complete;
    assign apb.pslverr = complete && access_err;
    assign apb.prdata  = (complete && !apb.pwrite) ? rd_mux : 8'h00;

    // Sticky status: software writes 0 to clear, hardware events always win.
    always_comb begin
        tsr_nxt = tsr;
        if (wr_commit && reg_sel == 2'd2) tsr_nxt = tsr & apb.pwdata[1:0];
        tsr_nxt = tsr_nxt | {udf_set, ovf_set};
    end

    // Control and status registers, updated only on a committed write.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr     <= 8'h00;
            load    <= 1'b0;
            dw      <= 1'b0;
            en      <= 1'b0;
            clk_sel <= 2'b00;
            tsr     <= 2'b00;
        end else begin
            tsr <= tsr_nxt;
            if (wr_commit && reg_sel == 2'd0) tdr <= apb.pwdata;
            if (wr_commit && reg_sel == 2'd1) begin
                load    <= apb.pwdata[7];
                dw      <= apb.pwdata[5];
                en      <= apb.pwdata[4];
                clk_sel <= apb.pwdata[1:0];
            end
        end
    end

endmodule

// File: tb/tb_timer_apb_slave.sv
// tb/tb_timer_apb_slave.sv - randomized self-checking bench for timer_apb_slave
module tb_timer_apb_slave;

    localparam int WAIT = 1;

    logic       pclk;
    logic       presetn;
    logic [7:0] tdr;
    logic       load, dw, en;
    logic [1:0] clk_sel;
    logic [7:0] cnt;
    logic       ovf_set, udf_set;
    logic [1:0] tsr;

    timer_apb_if #(.ADDR_W(8)) bus ();

    timer_apb_slave #(.WAIT_CYCLES(WAIT), .ADDR_W(8)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .apb     (bus),
        .tdr     (tdr),
        .load    (load),
        .dw      (dw),
        .en      (en),
        .clk_sel (clk_sel),
        .cnt     (cnt),
        .ovf_set (ovf_set),
        .udf_set (udf_set),
        .tsr     (tsr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;

    // reference register contents
    logic [7:0] m_tdr;
    logic [7:0] m_tcr;
    logic [1:0] m_tsr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_read(input logic [7:0] addr);
        case (addr)
            8'h00:   return m_tdr;
            8'h01:   return m_tcr;
            8'h02:   return {6'b0, m_tsr};
            8'h03:   return cnt;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic exp_err(input logic wr, input logic [7:0] addr);
        return (addr > 8'h03) || (wr && addr == 8'h03);
    endfunction

    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                            input logic pulse_ovf, output logic [7:0] rdata, output logic err);
        int   waits;
        logic done;
        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
        bus.paddr = addr; bus.pwdata = wdata;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        waits = 0; done = 1'b0; rdata = 8'h00; err = 1'b0;
        while (!done && waits < 20) begin
            @(negedge pclk);
            if (bus.pready) begin
                done  = 1'b1;
                rdata = bus.prdata;
                err   = bus.pslverr;
                if (pulse_ovf) ovf_set = 1'b1;
            end else begin
                waits++;
            end
        end
        check("timeout", {31'b0, done}, 32'd1);
        if (done) check("wait_states", {31'b0, (waits >= WAIT && waits <= WAIT + 1)}, 32'd1);
        @(posedge pclk); #1;
        bus.psel = 1'b0; bus.penable = 1'b0; ovf_set = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_tdr"}, {24'b0, tdr}, {24'b0, m_tdr});
        check({tag, "_ctl"}, {27'b0, load, dw, en, clk_sel},
              {27'b0, m_tcr[7], m_tcr[5], m_tcr[4], m_tcr[1:0]});
        check({tag, "_tsr"}, {30'b0, tsr}, {30'b0, m_tsr});
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [7:0] data, input logic pulse_ovf);
        logic [7:0] rd;
        logic       err;
        logic       e_err;
        e_err = exp_err(1'b1, addr);
        apb_xfer(1'b1, addr, data, pulse_ovf, rd, err);
        if (!e_err) begin
            case (addr)
                8'h00:   m_tdr = data;
                8'h01:   m_tcr = data & 8'hB3;
                8'h02:   m_tsr = m_tsr & data[1:0];
                default: ;
            endcase
        end
        if (pulse_ovf) m_tsr = m_tsr | 2'b01;
        check("wr_err", {31'b0, err}, {31'b0, e_err});
        check_outputs("wr");
    endtask

    task automatic do_read(input logic [7:0] addr);
        logic [7:0] rd;
        logic       err;
        logic [7:0] e_rd;
        e_rd = exp_read(addr);
        apb_xfer(1'b0, addr, 8'h00, 1'b0, rd, err);
        check("rd_data", {24'b0, rd}, {24'b0, e_rd});
        check("rd_err", {31'b0, err}, {31'b0, exp_err(1'b0, addr)});
        check_outputs("rd");
    endtask

    task automatic pulse(input logic o, input logic u);
        @(posedge pclk); #1;
        ovf_set = o; udf_set = u;
        @(posedge pclk); #1;
        ovf_set = 1'b0; udf_set = 1'b0;
        m_tsr = m_tsr | {u, o};
    endtask

    initial begin
        logic [7:0] a;
        presetn = 1'b0;
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
        bus.paddr = 8'h00; bus.pwdata = 8'h00;
        cnt = 8'h00; ovf_set = 1'b0; udf_set = 1'b0;
        m_tdr = 8'h00; m_tcr = 8'h00; m_tsr = 2'b00;
        repeat (3) @(posedge pclk);
        #1 presetn = 1'b1;
        @(negedge pclk);
        check_outputs("reset");
        check("reset_pready", {31'b0, bus.pready}, 32'd0);
        check("reset_pslverr", {31'b0, bus.pslverr}, 32'd0);
        check("reset_prdata", {24'b0, bus.prdata}, 32'd0);

        // control register fields and reserved bits
        do_write(8'h01, 8'h11, 1'b0);
        check("tcr11_en", {31'b0, en}, 32'd1);
        check("tcr11_clk_sel", {30'b0, clk_sel}, 32'd1);
        do_read(8'h01);
        do_write(8'h01, 8'hFF, 1'b0);
        do_read(8'h01);
        do_write(8'h00, 8'hA5, 1'b0);
        check("tdr_a5", {24'b0, tdr}, 32'hA5);
        do_read(8'h00);

        // sticky status behaviour
        pulse(1'b1, 1'b0);
        do_read(8'h02);
        do_write(8'h02, 8'h01, 1'b0);
        do_read(8'h02);
        do_write(8'h02, 8'h00, 1'b0);
        do_read(8'h02);
        do_write(8'h02, 8'h00, 1'b1);
        do_read(8'h02);
        pulse(1'b0, 1'b1);
        do_read(8'h02);
        check("tsr_both", {30'b0, tsr}, 32'd3);

        // errors and counter readback
        do_read(8'h10);
        do_write(8'h10, 8'h5C, 1'b0);
        do_write(8'h03, 8'h12, 1'b0);
        cnt = 8'h37;
        do_read(8'h03);

        // reset during a wait state of a TDR write
        @(posedge pclk); #1;
        bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
        bus.paddr = 8'h00; bus.pwdata = 8'h5A;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        @(negedge pclk);
        check("midreset_waiting", {31'b0, bus.pready}, 32'd0);
        presetn = 1'b0;
        #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
        m_tdr = 8'h00; m_tcr = 8'h00; m_tsr = 2'b00;
        check("midreset_pready", {31'b0, bus.pready}, 32'd0);
        check_outputs("midreset");
        @(posedge pclk); #1;
        presetn = 1'b1;
        do_write(8'h00, 8'h3C, 1'b0);
        do_read(8'h00);

        // randomized traffic against the reference model
        for (int i = 0; i < 60; i++) begin
            int sel;
            sel = $urandom_range(0, 5);
            if (sel < 4) a = 8'(sel);
            else a = 8'(4 + $urandom_range(0, 251));
            cnt = 8'($urandom);
            if ($urandom_range(0, 3) == 0) pulse(1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom), 1'b0);
            else do_read(a);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
